// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multicycle signed MULT/DIV sequencer owning the Hi/Lo registers
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ACC_W = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    // Multiply: {upper W, multiplier W, booth q-1}; divide: {remainder W+1, quotient W}
    logic [ACC_W-1:0] acc;
    // Multiplicand for MUL, divisor magnitude for DIV
    logic [WIDTH-1:0] mcand;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             dz;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH:0]   booth_upper;
    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   booth_sum;
    logic [ACC_W-1:0] booth_next;

    logic [ACC_W-1:0] div_shift;
    logic [WIDTH:0]   div_trial;
    logic [ACC_W-1:0] div_next;

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] fix_lo;
    logic [WIDTH-1:0] fix_hi;

    // Operand magnitudes taken at start; 2**(W-1) maps onto itself, which is its correct unsigned magnitude
    always_comb begin
        abs_a = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
        abs_b = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;
    end

    // One Booth step: add/subtract at W+1 bits so -2**(W-1) never overflows, then shift right by one
    always_comb begin
        booth_upper = {acc[ACC_W-1], acc[ACC_W-1:WIDTH+1]};
        mcand_ext   = {mcand[WIDTH-1], mcand};
        case (acc[1:0])
            2'b01:   booth_sum = booth_upper + mcand_ext;
            2'b10:   booth_sum = booth_upper - mcand_ext;
            default: booth_sum = booth_upper;
        endcase
        booth_next = {booth_sum, acc[WIDTH:1]};
    end

    // One restoring-division step: shift in the next dividend bit, keep the difference if it is non-negative
    always_comb begin
        div_shift = {acc[ACC_W-2:0], 1'b0};
        div_trial = div_shift[ACC_W-1:WIDTH] - {1'b0, mcand};
        if (div_trial[WIDTH]) begin
            div_next = div_shift;
        end else begin
            div_next = {div_trial, div_shift[WIDTH-1:1], 1'b1};
        end
    end

    // Sign fix-up for truncating division: quotient negative on sign mismatch, remainder follows the dividend
    always_comb begin
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        fix_lo = neg_q ? (~quo + WIDTH'(1)) : quo;
        fix_hi = neg_r ? (~rem + WIDTH'(1)) : rem;
    end

    // Control FSM with registered busy/done/div_zero and the architectural Hi/Lo registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        cnt    <= '0;
                        is_div <= op;
                        busy   <= 1'b1;
                        if (!op) begin
                            state <= S_MUL;
                            mcand <= op_a;
                            acc   <= {{WIDTH{1'b0}}, op_b, 1'b0};
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            dz    <= 1'b0;
                        end else if (op_b != '0) begin
                            state <= S_DIV;
                            mcand <= abs_b;
                            acc   <= {{(WIDTH + 1){1'b0}}, abs_a};
                            neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                            neg_r <= op_a[WIDTH-1];
                            dz    <= 1'b0;
                        end else begin
                            // Divide by zero skips iteration; FIX leaves Hi/Lo untouched
                            state <= S_FIX;
                            dz    <= 1'b1;
                        end
                    end
                end

                S_MUL: begin
                    acc <= booth_next;
                    if (cnt == LAST_STEP) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DIV: begin
                    acc <= div_next;
                    if (cnt == LAST_STEP) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_FIX: begin
                    if (!dz) begin
                        if (is_div) begin
                            hi <= fix_hi;
                            lo <= fix_lo;
                        end else begin
                            hi <= acc[ACC_W-1:WIDTH+1];
                            lo <= acc[WIDTH:1];
                        end
                    end
                    state    <= S_DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div_zero <= dz;
                end

                S_DONE: begin
                    // A start seen here is dropped; the requester re-issues from IDLE
                    state    <= S_IDLE;
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    dz       <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
